// File: rtl/ysyx_24100027_pkg.sv
// ============================================================================
// Module   : ysyx_24100027_pkg
// Purpose  : Shared types and constants for the instruction fetch unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_24100027_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;
    localparam logic [XLEN-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } ifu_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_24100027_Reg.sv
// ============================================================================
// Module   : ysyx_24100027_Reg
// Purpose  : Width-parameterised register with enable and sync active-low reset.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_24100027_Reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_24100027_ifu.sv
// ============================================================================
// Module   : ysyx_24100027_ifu
// Purpose  : Single-outstanding instruction fetch unit with redirect support.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_24100027_ifu
    import ysyx_24100027_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    ifu_state_e      state_q, state_d;
    logic            drop_q, drop_d;
    logic            req_valid_q;
    logic            inst_valid_q;
    logic            pc_en;
    logic            inst_en;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ALIGN_MASK;

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        pc_en   = 1'b0;
        pc_d    = pc_q;
        inst_en = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                    drop_d  = redirect_valid;
                end
            end
            ST_WAIT: begin
                // A redirect coinciding with the response kills that response too.
                if (imem_rsp_valid) begin
                    drop_d = 1'b0;
                    if (drop_q || redirect_valid) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_HOLD;
                        inst_en = 1'b1;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid || inst_ready) begin
                    state_d = ST_FETCH;
                    pc_en   = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (redirect_valid && (state_q != ST_IDLE)) begin
            pc_en = 1'b1;
            pc_d  = redirect_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            drop_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            req_valid_q  <= (state_d == ST_FETCH);
            inst_valid_q <= (state_d == ST_HOLD);
        end
    end

    ysyx_24100027_Reg #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc_q)
    );

    ysyx_24100027_Reg #(
        .WIDTH     (XLEN),
        .RESET_VAL ('0)
    ) u_inst_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (inst_en),
        .d     (imem_rsp_data),
        .q     (inst_q)
    );

    ysyx_24100027_Reg #(
        .WIDTH     (XLEN),
        .RESET_VAL ('0)
    ) u_inst_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (inst_en),
        .d     (pc_q),
        .q     (inst_pc_q)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100027_ifu.sv
// ============================================================================
// Module   : tb_ysyx_24100027_ifu
// Purpose  : Directed and randomized checks of the fetch unit against a
//            transaction-level model of fetch, response and consume events.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_24100027_ifu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        inst_ready = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;

    logic        req_valid;
    logic [31:0] addr;
    logic        ivalid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    // Second instance exercising the 32-bit PC wrap from a high reset vector.
    logic        one = 1'b1;
    logic        zero = 1'b0;
    logic [31:0] zero32 = '0;
    logic        d2_req_valid;
    logic [31:0] d2_addr;
    logic        d2_ivalid;
    logic [31:0] d2_inst;
    logic [31:0] d2_inst_pc;
    logic [31:0] d2_seen [2];
    int          d2_cnt = 0;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level model
    bit          m_idle, m_pending, m_cancel, m_offer;
    logic [31:0] m_pc, m_inst, m_inst_pc;

    ysyx_24100027_ifu u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_addr      (addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .inst_valid     (ivalid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redir),
        .redirect_pc    (redir_pc)
    );

    ysyx_24100027_ifu #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (d2_req_valid),
        .imem_req_ready (one),
        .imem_addr      (d2_addr),
        .imem_rsp_valid (one),
        .imem_rsp_data  (zero32),
        .inst_valid     (d2_ivalid),
        .inst_ready     (one),
        .inst           (d2_inst),
        .inst_pc        (d2_inst_pc),
        .redirect_valid (zero),
        .redirect_pc    (zero32)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            d2_cnt <= 0;
        end else if (d2_req_valid && d2_cnt < 2) begin
            d2_seen[d2_cnt] <= d2_addr;
            d2_cnt          <= d2_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_check();
        chk("req_valid", {31'b0, req_valid}, {31'b0, !m_idle && !m_pending && !m_offer});
        chk("imem_addr", addr, m_pc);
        chk("inst_valid", {31'b0, ivalid}, {31'b0, m_offer});
        if (m_offer) begin
            chk("inst", inst, m_inst);
            chk("inst_pc", inst_pc, m_inst_pc);
        end
    endtask

    // Event-level update: what the cycle's handshakes mean for the fetch stream.
    task automatic model_step(input bit rr, input bit rv, input logic [31:0] rd_data,
                              input bit ir, input bit rd, input logic [31:0] rp);
        logic [31:0] tgt;
        tgt = rp & 32'hFFFF_FFFC;
        if (m_idle) begin
            m_idle = 0;
        end else if (m_offer) begin
            if (rd) begin
                m_offer = 0;
                m_pc    = tgt;
            end else if (ir) begin
                m_offer = 0;
                m_pc    = m_pc + 32'd4;
            end
        end else if (m_pending) begin
            if (rv) begin
                m_pending = 0;
                if (!m_cancel && !rd) begin
                    m_offer   = 1;
                    m_inst    = rd_data;
                    m_inst_pc = m_pc;
                end
                m_cancel = 0;
            end else if (rd) begin
                m_cancel = 1;
            end
            if (rd) m_pc = tgt;
        end else begin
            if (rr) begin
                m_pending = 1;
                m_cancel  = rd;
            end
            if (rd) m_pc = tgt;
        end
    endtask

    task automatic cyc(input bit rr, input bit rv, input logic [31:0] rd_data,
                       input bit ir, input bit rd, input logic [31:0] rp);
        req_ready  = rr;
        rsp_valid  = rv;
        rsp_data   = rd_data;
        inst_ready = ir;
        redir      = rd;
        redir_pc   = rp;
        model_step(rr, rv, rd_data, ir, rd, rp);
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        inst_ready = 1'b0;
        redir      = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_idle    = 1;
        m_pending = 0;
        m_cancel  = 0;
        m_offer   = 0;
        m_pc      = 32'h8000_0000;
        chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("rst_inst_valid", {31'b0, ivalid}, 32'd0);
        chk("rst_addr", addr, 32'h8000_0000);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        do_reset();

        // Basic fetch: request, one-cycle response, consume
        cyc(1, 0, 0, 1, 0, 0);
        chk("first_req", {req_valid, addr[30:0]}, {1'b1, 31'h0000_0000});
        chk("first_addr", addr, 32'h8000_0000);
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 1, 32'h0000_0413, 1, 0, 0);
        chk("first_inst", inst, 32'h0000_0413);
        chk("first_inst_pc", inst_pc, 32'h8000_0000);
        cyc(1, 0, 0, 1, 0, 0);
        chk("second_addr", addr, 32'h8000_0004);

        // Decode stalls for five cycles
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'hCAFE_0093, 0, 0, 0);
        held = inst;
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
        chk("stall_inst", inst, held);
        cyc(0, 0, 0, 1, 0, 0);
        chk("resume_req", {31'b0, req_valid}, 32'd1);

        // Redirect during WAIT drops the response
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h8000_0100);
        cyc(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
        chk("drop_no_inst", {31'b0, ivalid}, 32'd0);
        chk("drop_addr", addr, 32'h8000_0100);

        // Redirect and consume in the same HOLD cycle
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h1111_2222, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'h8000_0203);
        chk("hold_redir_addr", addr, 32'h8000_0200);
        cyc(1, 0, 0, 1, 0, 0);
        chk("hold_redir_nodup", {31'b0, ivalid}, 32'd0);

        // Redirect in FETCH without and with acceptance
        cyc(0, 1, 32'h5555_5555, 0, 0, 0);
        cyc(1, 1, 32'h7777_7777, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h8000_0401);
        chk("fetch_redir_addr", addr, 32'h8000_0400);
        cyc(1, 0, 0, 0, 1, 32'h8000_0500);
        cyc(0, 1, 32'h3333_3333, 0, 0, 0);
        chk("fetch_drop_addr", addr, 32'h8000_0500);

        // High reset vector wraps to zero
        chk("wrap_count", d2_cnt, 32'd2);
        chk("wrap_first", d2_seen[0], 32'hFFFF_FFFC);
        chk("wrap_second", d2_seen[1], 32'h0000_0000);

        // Reset while waiting for a response
        cyc(1, 0, 0, 0, 0, 0);
        do_reset();
        cyc(0, 0, 0, 0, 0, 0);
        chk("post_rst_addr", addr, 32'h8000_0000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 1) == 1,
                    m_pending ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0),
                    $urandom,
                    $urandom_range(0, 4) < 3,
                    $urandom_range(0, 9) == 0,
                    $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
